// File: rtl/ls_seq.sv
// ls_seq: sequential logarithmic left shifter/rotator.
// The shift-by-1, -2, -4 ... stages are applied on successive clocks.
// A start/done handshake frames each operation.
//
// Handshake:
// - start is sampled only when idle (busy = 0). While busy = 1, start is
//   ignored; there is no queueing.
// - The cycle where start is taken captures I, S and ROT, and busy rises.
// - Exactly SW edges later, O holds the new result, done is high for one
//   cycle and busy is low. done and busy are never high together.
// - Because the FSM is already idle in the done cycle, a start in that
//   cycle is accepted.
module ls_seq #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           I,
    input  logic [SW-1:0]              S,
    input  logic                       ROT,
    output logic [WIDTH-1:0]           O,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(SW+1)-1:0]    o_state
);

    localparam int SB = $clog2(SW + 1);

    // IDLE is 0. Stage k is encoded as k+1, so the last stage is SW.
    localparam logic [SB-1:0] IDLE    = '0;
    localparam logic [SB-1:0] ST0     = SB'(1);
    localparam logic [SB-1:0] ST_LAST = SB'(SW);

    logic [SB-1:0]    r_state;
    logic [WIDTH-1:0] r_work;
    logic [SW-1:0]    r_amt;
    logic             r_mode;
    logic [WIDTH-1:0] r_o;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next;

    // Result of the stage selected by the current state.
    // In IDLE no stage matches, so the work value passes through unchanged.
    always_comb begin
        w_next = r_work;
        for (int k = 0; k < SW; k++) begin
            if (r_state == SB'(k + 1) && r_amt[k]) begin
                if (r_mode) begin
                    w_next = (r_work << (1 << k)) | (r_work >> (WIDTH - (1 << k)));
                end else begin
                    w_next = r_work << (1 << k);
                end
            end
        end
    end

    // Control FSM and datapath registers.
    // Reset aborts any in-flight operation without producing a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_amt   <= '0;
            r_mode  <= 1'b0;
            r_o     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_work  <= I;
                    r_amt   <= S;
                    r_mode  <= ROT;
                    r_busy  <= 1'b1;
                    r_state <= ST0;
                end
            end else begin
                r_work <= w_next;
                if (r_state == ST_LAST) begin
                    // O takes the post-stage value, not the pre-stage work value.
                    r_o     <= w_next;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_state <= r_state + SB'(1);
                end
            end
        end
    end

    assign O       = r_o;
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_ls_seq.sv
// Testbench for ls_seq: directed cases plus randomized operations checked
// against an arithmetic reference model.
module tb_ls_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] I;
  logic [2:0] S;
  logic       ROT;
  logic [7:0] O;
  logic       busy;
  logic       done;
  logic [1:0] o_state;

  int         vectors;
  int         errors;
  logic [7:0] last_o;

  ls_seq #(.WIDTH(8), .SW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .I       (I),
    .S       (S),
    .ROT     (ROT),
    .O       (O),
    .busy    (busy),
    .done    (done),
    .o_state (o_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: a rotate is the upper half of the doubled word shifted left;
  // a logical shift just drops the bits that leave the top.
  function automatic logic [7:0] model(input logic [7:0] i, input logic [2:0] s,
                                       input logic rot);
    logic [15:0] d;
    logic [7:0]  sh;
    d  = {i, i} << s;
    sh = i << s;
    return rot ? d[15:8] : sh;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one operation starting at the current time (just after an edge).
  // Inputs are scrambled while busy to show they are not re-sampled.
  task automatic run_op(input logic [7:0] i, input logic [2:0] s, input logic rot,
                        input logic [7:0] exp);
    I = i; S = s; ROT = rot; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_capture", 8'(busy), 8'h1);
    check("done_capture", 8'(done), 8'h0);
    check("o_hold_capture", O, last_o);
    for (int c = 1; c <= 2; c++) begin
      I = 8'($urandom); S = 3'($urandom); ROT = 1'($urandom);
      @(posedge clk); #1;
      check("busy_mid", 8'(busy), 8'h1);
      check("done_mid", 8'(done), 8'h0);
      check("o_hold_mid", O, last_o);
    end
    @(posedge clk); #1;
    check("done_final", 8'(done), 8'h1);
    check("busy_final", 8'(busy), 8'h0);
    check("o_result", O, exp);
    last_o = exp;
  endtask

  initial begin
    int gap;
    logic [7:0] ri;
    logic [2:0] rs;
    logic       rr;

    vectors = 0;
    errors  = 0;
    last_o  = 8'h00;
    rst = 1'b1; start = 1'b0; I = 8'h00; S = 3'd0; ROT = 1'b0;

    // Reset state.
    #2;
    check("rst_o", O, 8'h00);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_done", 8'(done), 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 8'(busy), 8'h0);

    // Directed shifts and rotates.
    run_op(8'hB3, 3'd3, 1'b0, 8'h98);
    @(posedge clk); #1;
    check("done_one_cycle", 8'(done), 8'h0);
    check("idle_after_done", 8'(busy), 8'h0);
    run_op(8'hB3, 3'd3, 1'b1, 8'h9D);
    run_op(8'hB3, 3'd7, 1'b0, 8'h80);
    run_op(8'hB3, 3'd7, 1'b1, 8'hD9);
    @(posedge clk); #1;

    // Zero shift, with a second start while busy that must be dropped.
    I = 8'h5A; S = 3'd0; ROT = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zs_busy0", 8'(busy), 8'h1);
    I = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zs_busy1", 8'(busy), 8'h1);
    check("zs_done1", 8'(done), 8'h0);
    @(posedge clk); #1;
    check("zs_done2", 8'(done), 8'h0);
    check("zs_o_hold", O, last_o);
    @(posedge clk); #1;
    check("zs_done3", 8'(done), 8'h1);
    check("zs_o", O, 8'h5A);
    last_o = 8'h5A;
    @(posedge clk); #1;
    check("zs_no_second_busy", 8'(busy), 8'h0);
    check("zs_no_second_done", 8'(done), 8'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("zs_quiet_done", 8'(done), 8'h0);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    run_op(8'hC1, 3'd2, 1'b1, 8'h07);
    run_op(8'h01, 3'd1, 1'b0, 8'h02);

    // Asynchronous reset in the middle of an operation.
    I = 8'hFF; S = 3'd5; ROT = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_o", O, 8'h00);
    check("mid_rst_busy", 8'(busy), 8'h0);
    check("mid_rst_done", 8'(done), 8'h0);
    last_o = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_done", 8'(done), 8'h0);
      check("post_rst_busy", 8'(busy), 8'h0);
      check("post_rst_o", O, 8'h00);
    end
    run_op(8'hB3, 3'd3, 1'b0, 8'h98);

    // Randomized operations with random idle gaps.
    repeat (40) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
        check("gap_done", 8'(done), 8'h0);
        check("gap_busy", 8'(busy), 8'h0);
        check("gap_o", O, last_o);
      end
      ri = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      rr = 1'($urandom);
      run_op(ri, rs, rr, model(ri, rs, rr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ls_seq.md
Name: ls_seq

Overview:
- Sequential 8-bit logarithmic left shifter/rotator with a start/done handshake.
- Mirror of the datapath right shifter: applies the shift-by-1, -2 and -4 stages over successive clocks instead of combinationally.
- Used where the left-shift direction is needed and registered, timing-friendly results with explicit completion signalling are required.

Parameters:
- WIDTH, 8, data width in bits. Must equal 2**SW.
- SW, 3, shift-amount width. Equals the number of shift stages and the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled on the rising clk edge when idle.
- I  input  WIDTH  operand. Captured with start.
- S  input  SW  left-shift amount, 0..WIDTH-1. Captured with start.
- ROT  input  1  0 = logical left shift (zero fill); 1 = rotate left. Captured with start.
- O  output  WIDTH  result register.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking that O holds a new result.

Behaviour:
- Reset: rst high forces asynchronously, independent of clk:
  - state = IDLE
  - O = 0, busy = 0, done = 0
  - internal operand, amount and mode registers = 0
- States: IDLE, ST0, ST1, ST2 (generalised: ST0..ST(SW-1)).
- IDLE:
  - start = 1 at an edge: capture I into the work register, S into the amount register, ROT into the mode register; go to ST0; busy = 1.
  - start = 0: stay in IDLE. O holds its last value.
- STk, k = 0..SW-1: at each edge,
  - if amt[k] = 1, the work register shifts left by 2**k. Logical mode fills zeros; rotate mode wraps the MSBs into the LSBs.
  - if amt[k] = 0, the work register is unchanged.
  - Then advance to ST(k+1).
- Final stage ST(SW-1): at its edge,
  - O is loaded with the stage result (not the pre-stage work value);
  - done = 1 for exactly one cycle;
  - busy = 0;
  - state = IDLE.
- Latency: start sampled at edge n gives O valid and done high after edge n+SW, i.e. edge n+3 for the defaults. busy is high after edges n+1..n+SW-1's intervals, i.e. from edge n until edge n+SW.
- start while busy: ignored. The captured operands are unaffected and no queueing occurs.
- Back-to-back: start asserted in the cycle where done = 1 is accepted, because the state is already IDLE. O keeps the prior result until the new operation's final edge.
- Input changes on I, S or ROT after capture have no effect on an in-flight operation.
- S = 0: O = I after the full SW-cycle latency. No early completion.
- Mid-operation reset: the operation is aborted with no done pulse. All outputs take their reset values.
- done and busy are never high in the same cycle.
- Widths: all internal registers are WIDTH or SW bits. No carry-out or overflow flag is produced; bits shifted out in logical mode are discarded.

Test Plan:
- Logical shift: rst pulse, then I = 8'hB3, S = 3, ROT = 0, start for 1 cycle.
  -> busy = 1 for 3 cycles, then done = 1 for 1 cycle, O = 8'h98, busy = 0.
- Rotate: I = 8'hB3, S = 3, ROT = 1, start.
  -> O = 8'h9D on done, 3 cycles after start.
- Maximum amount: I = 8'hB3, S = 7.
  -> ROT = 0 gives O = 8'h80; ROT = 1 gives O = 8'hD9. Each completes in 3 cycles.
- Zero shift and ignored start: I = 8'h5A, S = 0, start; change I to 8'hFF and pulse start again while busy.
  -> exactly one done pulse, O = 8'h5A at cycle 3, no second operation.
- Back-to-back: assert start in the done cycle with I = 8'h01, S = 1, ROT = 0.
  -> O keeps the prior result for 3 more cycles, then O = 8'h02 with a single done pulse.
- Reset mid-op: start with I = 8'hFF, S = 5; assert rst asynchronously between clock edges one cycle later.
  -> O = 0, busy = 0, done = 0 immediately; no done pulse afterwards; a following start behaves normally.
